// File: rtl/baud_gen_frac_if.sv
// Control/strobe bundle for the fractional baud generator.
//   master: drives en, dvsr_int, dvsr_frac, load, phase_clr; observes the strobes.
//   slave : the generator; drives load_ack, tick, bit_tick, mid_tick.
interface baud_gen_frac_if #(
  parameter int unsigned DVSR_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = 4
);
  logic                  en;
  logic [DVSR_WIDTH-1:0] dvsr_int;
  logic [FRAC_WIDTH-1:0] dvsr_frac;
  logic                  load;
  logic                  phase_clr;
  logic                  load_ack;
  logic                  tick;
  logic                  bit_tick;
  logic                  mid_tick;

  modport master (
    output en, dvsr_int, dvsr_frac, load, phase_clr,
    input  load_ack, tick, bit_tick, mid_tick
  );

  modport slave (
    input  en, dvsr_int, dvsr_frac, load, phase_clr,
    output load_ack, tick, bit_tick, mid_tick
  );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator for the UART datapath.
// Average tick period is int_q + 1 + frac_q / 2^FRAC_WIDTH clocks; bit_tick and
// mid_tick mark the last and the middle tick of every OSR-tick bit.
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   bus.en        count enable (counters hold while low)
//   bus.dvsr_int  requested integer divisor (period = value + 1 clocks)
//   bus.dvsr_frac requested fractional divisor, 1/2^FRAC_WIDTH clock units
//   bus.load      capture requested divisor into the shadow register
//   bus.phase_clr synchronous restart of period/accumulator/OSR counters
//   bus.load_ack  1-cycle pulse when the shadow divisor becomes active
//   bus.tick, bus.bit_tick, bus.mid_tick  registered 1-cycle strobes
module baud_gen_frac #(
  parameter int unsigned DVSR_WIDTH = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OSR        = 16,
  parameter int unsigned RST_INT    = 324,
  parameter int unsigned RST_FRAC   = 8
) (
  input logic            clk,
  input logic            reset,
  baud_gen_frac_if.slave bus
);

  localparam int unsigned OsrW = (OSR > 1) ? $clog2(OSR) : 1;

  // One spare bit so int_q + stretch never wraps at the maximum divisor.
  logic [DVSR_WIDTH:0]   cnt_q;
  logic [DVSR_WIDTH-1:0] int_q, sh_int_q;
  logic [FRAC_WIDTH-1:0] frac_q, sh_frac_q, acc_q;
  logic                  stretch_q, pending_q;
  logic [OsrW-1:0]       osr_q;
  logic                  tick_q, bit_q, mid_q, ack_q;

  logic [DVSR_WIDTH:0]   term_val;
  logic [FRAC_WIDTH:0]   acc_sum;
  logic                  terminal;
  logic                  apply;

  assign term_val = {1'b0, int_q} + {{DVSR_WIDTH{1'b0}}, stretch_q};
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_q};
  assign terminal = bus.en && !bus.phase_clr && (cnt_q == term_val);
  // A pending divisor swaps in at a period boundary, or at once when the
  // period is frozen (en low) or being restarted (phase_clr).
  assign apply    = pending_q && (terminal || !bus.en || bus.phase_clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
      osr_q     <= '0;
      int_q     <= DVSR_WIDTH'(RST_INT);
      frac_q    <= FRAC_WIDTH'(RST_FRAC);
      sh_int_q  <= '0;
      sh_frac_q <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      bit_q     <= 1'b0;
      mid_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      bit_q  <= 1'b0;
      mid_q  <= 1'b0;
      ack_q  <= apply;

      if (bus.phase_clr) begin
        cnt_q     <= '0;
        acc_q     <= '0;
        stretch_q <= 1'b0;
        osr_q     <= '0;
      end else if (bus.en) begin
        if (terminal) begin
          cnt_q     <= '0;
          tick_q    <= 1'b1;
          acc_q     <= acc_sum[FRAC_WIDTH-1:0];
          // Accumulator carry lengthens the following period by one clock.
          stretch_q <= acc_sum[FRAC_WIDTH];
          if (osr_q == OsrW'(OSR - 1)) begin
            bit_q <= 1'b1;
            osr_q <= '0;
          end else begin
            osr_q <= osr_q + 1'b1;
          end
          if (osr_q == OsrW'(OSR / 2 - 1)) begin
            mid_q <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      // New divisor starts with a clean fractional phase.
      if (apply) begin
        int_q     <= sh_int_q;
        frac_q    <= sh_frac_q;
        acc_q     <= '0;
        stretch_q <= 1'b0;
      end

      // A load on an apply edge refills the shadow and stays pending.
      if (bus.load) begin
        sh_int_q  <= bus.dvsr_int;
        sh_frac_q <= bus.dvsr_frac;
        pending_q <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.tick     = tick_q;
  assign bus.bit_tick = bit_q;
  assign bus.mid_tick = mid_q;
  assign bus.load_ack = ack_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: period-level reference model checked
// every cycle, a table of divisor vectors, and directed corner sequences.
module tb_baud_gen_frac;

  localparam int DW       = 16;
  localparam int FW       = 4;
  localparam int OSR      = 16;
  localparam int RST_INT  = 324;
  localparam int RST_FRAC = 8;
  localparam int M        = 1 << FW;

  logic clk = 1'b0;
  logic reset;

  baud_gen_frac_if #(.DVSR_WIDTH(DW), .FRAC_WIDTH(FW)) bus ();

  baud_gen_frac #(
    .DVSR_WIDTH(DW),
    .FRAC_WIDTH(FW),
    .OSR       (OSR),
    .RST_INT   (RST_INT),
    .RST_FRAC  (RST_FRAC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_seen = 0;

  // Reference model: period n after a realign lasts int+1 clocks plus the
  // growth of floor(n*frac/2^FW) over that period (period 0 never stretches).
  int m_int, m_frac, m_sh_int, m_sh_frac;
  bit m_pend;
  int m_e, m_n, m_k;
  bit e_tick, e_bit, e_mid, e_ack;

  function automatic int period_len(input int n);
    int extra;
    extra = (n == 0) ? 0 : ((n * m_frac) / M - ((n - 1) * m_frac) / M);
    return m_int + 1 + extra;
  endfunction

  task automatic model_reset();
    m_int = RST_INT; m_frac = RST_FRAC; m_sh_int = 0; m_sh_frac = 0; m_pend = 0;
    m_e = 0; m_n = 0; m_k = 0;
    e_tick = 0; e_bit = 0; e_mid = 0; e_ack = 0;
  endtask

  task automatic model_step();
    bit term, app;
    term = bus.en && !bus.phase_clr && (m_e + 1 == period_len(m_n));
    app  = m_pend && (bus.phase_clr || !bus.en || term);
    e_tick = 0; e_bit = 0; e_mid = 0;
    if (bus.phase_clr) begin
      m_e = 0; m_n = 0; m_k = 0;
    end else if (bus.en) begin
      if (term) begin
        e_tick = 1;
        m_k = (m_k + 1) % OSR;
        e_bit = (m_k == 0);
        e_mid = (m_k == OSR / 2);
        m_e = 0;
        m_n = m_n + 1;
      end else begin
        m_e = m_e + 1;
      end
    end
    e_ack = app;
    if (app) begin
      m_int = m_sh_int; m_frac = m_sh_frac; m_n = 0;
    end
    if (bus.load) begin
      m_sh_int = int'(bus.dvsr_int); m_sh_frac = int'(bus.dvsr_frac); m_pend = 1;
    end else if (app) begin
      m_pend = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event, required event (t=%0t)", name, $time);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check("tick", bus.tick, e_tick);
    check("bit_tick", bus.bit_tick, e_bit);
    check("mid_tick", bus.mid_tick, e_mid);
    check("load_ack", bus.load_ack, e_ack);
    if (bus.load_ack) ack_seen++;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick && n < budget);
    if (!bus.tick) timeout("wait_tick");
  endtask

  task automatic set_div(input int di, input int df);
    int n;
    bus.dvsr_int = DW'(di);
    bus.dvsr_frac = FW'(df);
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.load_ack && n < 2000);
    if (!bus.load_ack) timeout("set_div_ack");
  endtask

  typedef struct {
    int          dint;
    int          dfrac;
    logic [35:0] pat;    // periods 0..8 as hex digits, left to right
    int          clk16;  // clocks in periods 1..16
  } vec_t;

  initial begin
    #5ms;
    $display("FAIL watchdog: got still running, required finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[7];
    int   n, sum, a0;
    tbl[0] = '{3, 0, 36'h444444444, 64};
    tbl[1] = '{3, 4, 36'h444454445, 68};
    tbl[2] = '{0, 0, 36'h111111111, 16};
    tbl[3] = '{0, 8, 36'h112121212, 24};
    tbl[4] = '{9, 15, 36'hAABBBBBBB, 175};
    tbl[5] = '{1, 1, 36'h222222222, 33};
    tbl[6] = '{2, 12, 36'h334443444, 60};

    reset = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.phase_clr = 1'b0;
    bus.dvsr_int = '0; bus.dvsr_frac = '0;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;

    // Load 3/0 while disabled: applies on the next edge.
    bus.dvsr_int = 16'd3; bus.dvsr_frac = 4'd0; bus.load = 1'b1;
    cyc();
    check("ack_early", bus.load_ack, 0);
    bus.load = 1'b0;
    cyc();
    check("ack_en0", bus.load_ack, 1);
    cyc();
    check("ack_width", bus.load_ack, 0);
    bus.en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      wait_tick(50, n);
      check("p1_period", n, 4);
      check("p1_bit", bus.bit_tick, i == 16);
      check("p1_mid", bus.mid_tick, i == 8 || i == 24);
    end

    // Divisor table: period pattern and clocks per 16 steady periods.
    for (int r = 0; r < 7; r++) begin
      set_div(tbl[r].dint, tbl[r].dfrac);
      check("tbl_ack_tick", bus.tick, 1);
      sum = 0;
      for (int j = 0; j <= 16; j++) begin
        wait_tick(100, n);
        if (j <= 8) check("tbl_period", n, int'(tbl[r].pat[32 - 4 * j +: 4]));
        if (j >= 1) sum += n;
      end
      check("tbl_clk16", sum, tbl[r].clk16);
    end

    // Load mid-period: current period keeps the old divisor.
    set_div(3, 0);
    wait_tick(50, n);
    cyc();
    bus.dvsr_int = 16'd9; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    wait_tick(50, n);
    check("mid_load_period", n + 2, 4);
    check("mid_load_ack", bus.load_ack, 1);
    wait_tick(50, n);
    check("new_period_a", n, 10);
    wait_tick(50, n);
    check("new_period_b", n, 10);

    // Two loads before one terminal: single ack, last value wins.
    a0 = ack_seen;
    bus.dvsr_int = 16'd5; bus.load = 1'b1;
    cyc();
    bus.dvsr_int = 16'd7;
    cyc();
    bus.load = 1'b0;
    wait_tick(50, n);
    check("dbl_old_period", n + 2, 10);
    check("dbl_ack_count", ack_seen - a0, 1);
    wait_tick(50, n);
    check("dbl_new_period", n, 8);
    check("dbl_ack_once", ack_seen - a0, 1);

    // phase_clr landing on the terminal edge at osr_cnt = 11.
    set_div(3, 0);
    bus.phase_clr = 1'b1;
    cyc();
    bus.phase_clr = 1'b0;
    for (int i = 0; i < 11; i++) wait_tick(50, n);
    cyc(); cyc(); cyc();
    bus.phase_clr = 1'b1;
    cyc();
    check("clr_tick", bus.tick, 0);
    check("clr_bit", bus.bit_tick, 0);
    check("clr_mid", bus.mid_tick, 0);
    bus.phase_clr = 1'b0;
    wait_tick(50, n);
    check("clr_first", n, 4);
    for (int i = 2; i <= 16; i++) begin
      wait_tick(50, n);
      check("clr_bit_pos", bus.bit_tick, i == 16);
      check("clr_mid_pos", bus.mid_tick, i == 8);
    end

    // en low for 7 cycles mid-period stretches it by exactly 7.
    wait_tick(50, n);
    cyc();
    bus.en = 1'b0;
    repeat (7) cyc();
    bus.en = 1'b1;
    wait_tick(50, n);
    check("en_gap_period", n + 8, 11);

    // Load on a terminal edge stays pending; async reset then drops it.
    cyc(); cyc(); cyc();
    bus.dvsr_int = 16'd5; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("pre_rst_tick", bus.tick, 1);
    check("pre_rst_ack", bus.load_ack, 0);
    #2 reset = 1'b1;
    #1;
    check("rst_tick", bus.tick, 0);
    check("rst_bit", bus.bit_tick, 0);
    check("rst_mid", bus.mid_tick, 0);
    check("rst_ack", bus.load_ack, 0);
    model_reset();
    cyc();
    reset = 1'b0;
    a0 = ack_seen;
    wait_tick(400, n);
    check("rst_default_period", n, RST_INT + 1);
    check("rst_no_ack", ack_seen - a0, 0);

    // Randomized run against the model; en only drops with nothing pending.
    set_div(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)));
    for (int c = 0; c < 3000; c++) begin
      bus.phase_clr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 4) begin
        bus.load = 1'b1;
        bus.dvsr_int = DW'($urandom_range(0, 6));
        bus.dvsr_frac = FW'($urandom_range(0, 15));
        bus.en = 1'b1;
      end else begin
        bus.load = 1'b0;
        if (!m_pend && $urandom_range(0, 99) < 5) bus.en = ~bus.en;
      end
      cyc();
    end
    bus.load = 1'b0;
    bus.phase_clr = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
